// File: rtl/serial_link_pwr_seq.sv
// -----------------------------------------------------------------------------
// serial_link_pwr_seq
//
// Power sequencer for a multi-channel serial link. A Moore FSM walks the link
// through clock enable, reset release, de-isolation and operation on bring-up,
// and through isolation, reset assertion and clock gating on teardown. A single
// shared down-counter times the fixed reset-phase holds and bounds the wait for
// the isolation acknowledge.
//
// All link-facing outputs and state_o are registered decodes of the current
// state. They therefore appear one clock after the state they describe, and no
// input reaches an output combinationally.
//
// Parameters
//   NumChannels   : channels with their own clock gate (1..16)
//   NumIsoPorts   : isolation ports (0 = ingress, 1 = egress)
//   RstHoldCycles : cycles spent in each reset-phase state (>= 1)
//   IsoTimeout    : cycles allowed for the isolation acknowledge, 0 = no limit
//
// Ports
//   clk_i         : clock
//   rst_ni        : asynchronous active-low reset
//   up_req_i      : level request to bring the link up
//   down_req_i    : level request to take the link down (wins over up_req_i)
//   chan_en_i     : per-channel enable mask, gates clk_ena_o
//   isolated_i    : isolation acknowledge from each isolate stage
//   err_clr_i     : clears the sticky timeout flag
//   clk_ena_o     : per-channel clock-gate enable
//   reset_no      : active-low link reset
//   isolate_o     : isolation request per port
//   link_up_o     : link operational
//   busy_o        : sequencing in progress (any state other than OFF / ON)
//   err_timeout_o : sticky isolation-acknowledge timeout flag
//   state_o       : FSM state code
// -----------------------------------------------------------------------------
module serial_link_pwr_seq #(
    parameter int NumChannels   = 1,
    parameter int NumIsoPorts   = 2,
    parameter int RstHoldCycles = 8,
    parameter int IsoTimeout    = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   up_req_i,
    input  logic                   down_req_i,
    input  logic [NumChannels-1:0] chan_en_i,
    input  logic [NumIsoPorts-1:0] isolated_i,
    input  logic                   err_clr_i,
    output logic [NumChannels-1:0] clk_ena_o,
    output logic                   reset_no,
    output logic [NumIsoPorts-1:0] isolate_o,
    output logic                   link_up_o,
    output logic                   busy_o,
    output logic                   err_timeout_o,
    output logic [2:0]             state_o
);

    // ------------------------------------------------------------------
    // Counter sizing: wide enough for the longer of the two intervals.
    // ------------------------------------------------------------------
    localparam int MaxCnt = (RstHoldCycles > IsoTimeout) ? RstHoldCycles : IsoTimeout;
    localparam int CntW   = $clog2(MaxCnt + 1);

    // The counter is loaded with (interval - 1) on entry and the state is left
    // on the edge that observes zero, giving exactly 'interval' cycles.
    localparam logic [CntW-1:0] HoldLoad  = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] IsoLoad   = (IsoTimeout > 0) ? CntW'(IsoTimeout - 1) : '0;
    localparam bit              TimeoutEn = (IsoTimeout > 0);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_CLK_ON     = 3'd1,
        ST_RST_REL    = 3'd2,
        ST_DEISO      = 3'd3,
        ST_ON         = 3'd4,
        ST_ISO        = 3'd5,
        ST_RST_ASSERT = 3'd6
    } state_e;

    state_e            state_reg, state_next;
    logic [CntW-1:0]   cnt_reg, cnt_next;
    logic              abort_pend_reg, abort_pend_next;
    logic              err_reg, err_next;
    logic              timeout_hit;
    logic              cnt_done;
    logic              iso_all_clear;
    logic              iso_all_set;

    // Registered output images
    logic [NumChannels-1:0] clk_ena_reg, clk_ena_next;
    logic [NumIsoPorts-1:0] isolate_reg, isolate_next;
    logic                   reset_n_reg;
    logic                   link_up_reg;
    logic                   busy_reg;
    logic [2:0]             state_o_reg;

    // State decode feeding the output registers
    logic dec_clk_on;
    logic dec_rst_rel;
    logic dec_iso_req;
    logic dec_link_up;
    logic dec_busy;

    assign cnt_done      = (cnt_reg == '0);
    assign iso_all_clear = ~|isolated_i;
    assign iso_all_set   = &isolated_i;

    // Counter value to load when a state is entered.
    function automatic logic [CntW-1:0] entry_load(input state_e st);
        case (st)
            ST_CLK_ON, ST_RST_REL, ST_RST_ASSERT: entry_load = HoldLoad;
            ST_DEISO, ST_ISO:                     entry_load = IsoLoad;
            default:                              entry_load = '0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_OFF;
            cnt_reg        <= '0;
            abort_pend_reg <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            abort_pend_reg <= abort_pend_next;
            err_reg        <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;

        case (state_reg)
            ST_OFF: begin
                if (up_req_i && !down_req_i) begin
                    state_next = ST_CLK_ON;
                end
            end

            // A down request seen during either reset hold does not cut the
            // hold short; it only redirects the exit to RST_ASSERT.
            ST_CLK_ON: begin
                if (cnt_done) begin
                    state_next = (abort_pend_reg || down_req_i) ? ST_RST_ASSERT : ST_RST_REL;
                end
            end

            ST_RST_REL: begin
                if (cnt_done) begin
                    state_next = (abort_pend_reg || down_req_i) ? ST_RST_ASSERT : ST_DEISO;
                end
            end

            // Down request beats a simultaneous acknowledge: once teardown is
            // requested the link must not be reported up.
            ST_DEISO: begin
                if (down_req_i) begin
                    state_next = ST_ISO;
                end else if (iso_all_clear) begin
                    state_next = ST_ON;
                end else if (TimeoutEn && cnt_done) begin
                    state_next  = ST_ISO;
                    timeout_hit = 1'b1;
                end
            end

            ST_ON: begin
                if (down_req_i) begin
                    state_next = ST_ISO;
                end
            end

            // A missing acknowledge here forces teardown anyway.
            ST_ISO: begin
                if (iso_all_set) begin
                    state_next = ST_RST_ASSERT;
                end else if (TimeoutEn && cnt_done) begin
                    state_next  = ST_RST_ASSERT;
                    timeout_hit = 1'b1;
                end
            end

            ST_RST_ASSERT: begin
                if (cnt_done) begin
                    state_next = ST_OFF;
                end
            end

            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared counter, pending-abort latch and sticky error
    // ------------------------------------------------------------------
    always_comb begin
        cnt_next        = cnt_reg;
        abort_pend_next = abort_pend_reg;

        if (state_next != state_reg) begin
            cnt_next        = entry_load(state_next);
            abort_pend_next = 1'b0;
        end else begin
            if (!cnt_done) begin
                cnt_next = cnt_reg - CntW'(1);
            end
            if ((state_reg == ST_CLK_ON || state_reg == ST_RST_REL) && down_req_i) begin
                abort_pend_next = 1'b1;
            end
        end
    end

    // Setting wins over a clear in the same cycle so a fresh timeout is
    // never lost.
    always_comb begin
        err_next = err_reg;
        if (timeout_hit) begin
            err_next = 1'b1;
        end else if (err_clr_i) begin
            err_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        dec_clk_on  = (state_reg != ST_OFF);
        dec_rst_rel = (state_reg == ST_RST_REL) || (state_reg == ST_DEISO) ||
                      (state_reg == ST_ON)      || (state_reg == ST_ISO);
        dec_iso_req = !((state_reg == ST_DEISO) || (state_reg == ST_ON));
        dec_link_up = (state_reg == ST_ON);
        dec_busy    = !((state_reg == ST_OFF) || (state_reg == ST_ON));
    end

    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_clk_ena
            assign clk_ena_next[gi] = dec_clk_on & chan_en_i[gi];
        end
        for (genvar gi = 0; gi < NumIsoPorts; gi++) begin : g_isolate
            assign isolate_next[gi] = dec_iso_req;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_ena_reg <= '0;
            isolate_reg <= '1;
            reset_n_reg <= 1'b0;
            link_up_reg <= 1'b0;
            busy_reg    <= 1'b0;
            state_o_reg <= 3'd0;
        end else begin
            clk_ena_reg <= clk_ena_next;
            isolate_reg <= isolate_next;
            reset_n_reg <= dec_rst_rel;
            link_up_reg <= dec_link_up;
            busy_reg    <= dec_busy;
            state_o_reg <= state_reg;
        end
    end

    assign clk_ena_o     = clk_ena_reg;
    assign isolate_o     = isolate_reg;
    assign reset_no      = reset_n_reg;
    assign link_up_o     = link_up_reg;
    assign busy_o        = busy_reg;
    assign err_timeout_o = err_reg;
    assign state_o       = state_o_reg;

endmodule

// File: tb/tb_serial_link_pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_link_pwr_seq
//
// Drives serial_link_pwr_seq (4 channels, 2 isolation ports, 4-cycle holds,
// 16-cycle isolation timeout) cycle by cycle. Each vector carries the inputs
// applied before a clock edge and the state code expected on state_o after
// it; the remaining outputs are derived from the per-state output table.
// Expected records are queued when a vector is driven and popped when the
// outputs are sampled one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_serial_link_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       up_req;
    logic       down_req;
    logic [3:0] chan_en;
    logic [1:0] isolated;
    logic       err_clr;
    logic [3:0] clk_ena;
    logic       reset_n_out;
    logic [1:0] isolate;
    logic       link_up;
    logic       busy;
    logic       err_timeout;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    serial_link_pwr_seq #(
        .NumChannels  (4),
        .NumIsoPorts  (2),
        .RstHoldCycles(4),
        .IsoTimeout   (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .up_req_i     (up_req),
        .down_req_i   (down_req),
        .chan_en_i    (chan_en),
        .isolated_i   (isolated),
        .err_clr_i    (err_clr),
        .clk_ena_o    (clk_ena),
        .reset_no     (reset_n_out),
        .isolate_o    (isolate),
        .link_up_o    (link_up),
        .busy_o       (busy),
        .err_timeout_o(err_timeout),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] clk;
        logic       rstn;
        logic [1:0] iso;
        logic       link;
        logic       busy;
        logic       err;
    } out_t;

    typedef struct packed {
        logic       up;
        logic       dn;
        logic [3:0] ce;
        logic [1:0] iso;
        logic       clr;
        logic [2:0] st;
        logic       err;
    } vec_t;

    out_t exp_q[$];
    vec_t tbl[$];

    // Per-state output table: 0 OFF, 1 CLK_ON, 2 RST_REL, 3 DEISO, 4 ON,
    // 5 ISO, 6 RST_ASSERT.
    function automatic out_t exp_out(input logic [2:0] st, input logic [3:0] ce, input logic err);
        out_t o;
        logic clk_on;
        o.st   = st;
        o.err  = err;
        o.link = 1'b0;
        o.busy = 1'b1;
        clk_on = 1'b1;
        case (st)
            3'd0:    begin clk_on = 1'b0; o.rstn = 1'b0; o.iso = 2'b11; o.busy = 1'b0; end
            3'd1:    begin o.rstn = 1'b0; o.iso = 2'b11; end
            3'd2:    begin o.rstn = 1'b1; o.iso = 2'b11; end
            3'd3:    begin o.rstn = 1'b1; o.iso = 2'b00; end
            3'd4:    begin o.rstn = 1'b1; o.iso = 2'b00; o.link = 1'b1; o.busy = 1'b0; end
            3'd5:    begin o.rstn = 1'b1; o.iso = 2'b11; end
            default: begin o.rstn = 1'b0; o.iso = 2'b11; end
        endcase
        o.clk = clk_on ? ce : 4'b0000;
        return o;
    endfunction

    task automatic check(input string nm);
        out_t e;
        out_t a;
        a = '{state, clk_ena, reset_n_out, isolate, link_up, busy, err_timeout};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got st=%0d", nm, a.st);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got st=%0d clk=%b rstn=%b iso=%b up=%b busy=%b err=%b, want st=%0d clk=%b rstn=%b iso=%b up=%b busy=%b err=%b",
                         nm, a.st, a.clk, a.rstn, a.iso, a.link, a.busy, a.err,
                         e.st, e.clk, e.rstn, e.iso, e.link, e.busy, e.err);
            end
        end
    endtask

    // Drive one vector, push its expectation, clock once and compare.
    task automatic apply(input vec_t v, input string nm);
        up_req   = v.up;
        down_req = v.dn;
        chan_en  = v.ce;
        isolated = v.iso;
        err_clr  = v.clr;
        exp_q.push_back(exp_out(v.st, v.ce, v.err));
        @(posedge clk);
        #1;
        check(nm);
    endtask

    task automatic add(input int n, input logic up, input logic dn, input logic [3:0] ce,
                       input logic [1:0] iso, input logic clr, input logic [2:0] st, input logic err);
        vec_t v;
        v = '{up, dn, ce, iso, clr, st, err};
        repeat (n) tbl.push_back(v);
    endtask

    task automatic step(input int n, input logic up, input logic dn, input logic [3:0] ce,
                        input logic [1:0] iso, input logic clr, input logic [2:0] st, input logic err,
                        input string nm);
        vec_t v;
        v = '{up, dn, ce, iso, clr, st, err};
        for (int i = 0; i < n; i++) apply(v, $sformatf("%s_%0d", nm, i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Bring-up: up_req held from edge 0, acknowledge drops two cycles
        // after isolate_o falls (edge 9), then the channel mask changes in ON.
        add(1, 1, 0, 4'b0001, 2'b11, 0, 3'd0, 0);   // edge 0
        add(4, 1, 0, 4'b0001, 2'b11, 0, 3'd1, 0);   // edges 1-4: clk_ena up at 1
        add(4, 1, 0, 4'b0001, 2'b11, 0, 3'd2, 0);   // edges 5-8: reset_no up at 5
        add(2, 1, 0, 4'b0001, 2'b11, 0, 3'd3, 0);   // edges 9-10: isolate_o low at 9
        add(1, 1, 0, 4'b0001, 2'b00, 0, 3'd3, 0);   // edge 11: ack all-zero sampled
        add(1, 1, 0, 4'b0001, 2'b00, 0, 3'd4, 0);   // edge 12: link_up_o
        add(1, 1, 0, 4'b0101, 2'b00, 0, 3'd4, 0);   // edge 13: mask 0101 visible
        // Teardown: down in ON, ack all-ones three cycles into ISO.
        add(1, 1, 1, 4'b0101, 2'b00, 0, 3'd4, 0);
        add(2, 1, 1, 4'b0101, 2'b00, 0, 3'd5, 0);
        add(1, 1, 1, 4'b0101, 2'b11, 0, 3'd5, 0);
        add(4, 1, 1, 4'b0101, 2'b11, 0, 3'd6, 0);
        add(1, 1, 1, 4'b0101, 2'b11, 0, 3'd0, 0);   // OFF, clocks gated
        // Both requests in OFF: must stay OFF.
        add(2, 1, 1, 4'b0101, 2'b11, 0, 3'd0, 0);

        rst_n    = 1'b1;
        up_req   = 1'b0;
        down_req = 1'b0;
        chan_en  = 4'b0000;
        isolated = 2'b11;
        err_clr  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        exp_q.push_back(exp_out(3'd0, 4'b0000, 1'b0));
        check("reset_state");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // DEISO timeout with the acknowledge stuck high; a clear in the
        // timeout cycle loses to the set, a clear one cycle later wins.
        step(1,  1, 0, 4'b0011, 2'b11, 0, 3'd0, 0, "to_off");
        step(4,  0, 0, 4'b0011, 2'b11, 0, 3'd1, 0, "to_clkon");
        step(4,  0, 0, 4'b0011, 2'b11, 0, 3'd2, 0, "to_rstrel");
        step(15, 0, 0, 4'b0011, 2'b11, 0, 3'd3, 0, "to_deiso");
        step(1,  0, 0, 4'b0011, 2'b11, 1, 3'd3, 1, "to_set_wins");
        step(1,  0, 0, 4'b0011, 2'b11, 1, 3'd5, 0, "to_clear");
        step(4,  0, 0, 4'b0011, 2'b11, 0, 3'd6, 0, "to_rstassert");
        step(1,  0, 0, 4'b0011, 2'b11, 0, 3'd0, 0, "to_done");

        // Both requests in DEISO: abort to ISO.
        step(1, 1, 0, 4'b1111, 2'b11, 0, 3'd0, 0, "both_off");
        step(4, 0, 0, 4'b1111, 2'b11, 0, 3'd1, 0, "both_clkon");
        step(4, 0, 0, 4'b1111, 2'b11, 0, 3'd2, 0, "both_rstrel");
        step(1, 1, 1, 4'b1111, 2'b11, 0, 3'd3, 0, "both_deiso");
        step(1, 0, 0, 4'b1111, 2'b11, 0, 3'd5, 0, "both_iso");
        step(4, 0, 0, 4'b1111, 2'b11, 0, 3'd6, 0, "both_rstassert");
        step(1, 0, 0, 4'b1111, 2'b11, 0, 3'd0, 0, "both_done");

        // Reset asserted while in RST_REL.
        step(1, 1, 0, 4'b1000, 2'b11, 0, 3'd0, 0, "mid_off");
        step(4, 0, 0, 4'b1000, 2'b11, 0, 3'd1, 0, "mid_clkon");
        step(1, 0, 0, 4'b1000, 2'b11, 0, 3'd2, 0, "mid_rstrel");
        #3 rst_n = 1'b0;
        #1;
        exp_q.push_back(exp_out(3'd0, 4'b1000, 1'b0));
        check("mid_async_reset");
        up_req = 1'b1;
        #2 rst_n = 1'b1;

        // Restart from CLK_ON; a one-cycle down pulse during the CLK_ON hold
        // must still finish the hold and then go to RST_ASSERT.
        step(1, 1, 0, 4'b1000, 2'b11, 0, 3'd0, 0, "restart_off");
        step(1, 0, 1, 4'b1000, 2'b11, 0, 3'd1, 0, "restart_clkon_dn");
        step(3, 0, 0, 4'b1000, 2'b11, 0, 3'd1, 0, "restart_clkon");
        step(4, 0, 0, 4'b1000, 2'b11, 0, 3'd6, 0, "abort_rstassert");
        step(1, 0, 0, 4'b1000, 2'b11, 0, 3'd0, 0, "abort_off");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
